sys_bus_router: RTL and testbench
=================================

Name: sys_bus_router

Overview:
Parametrised N-slave system-bus router between the RISC-V pipeline's data port and its memory-mapped slaves: data memory, GEMM config space, and future peripherals.
- Generalises the fixed two-way memory/GEMM split into N slaves, each selected by a programmable tag in address bits [31:28].
- Supports variable-latency slave reads through a per-slave read-valid handshake, with master stall.
- Returns an error response for unmapped addresses and slave timeouts, and logs errors.

Parameters:
NUM_SLAVES, 2, number of slave ports (1..8)
TAG_W, 4, width of the decode field taken from m_addr[31:32-TAG_W]
SLAVE_TAGS, {4'h0,4'h9}, packed NUM_SLAVES*TAG_W tag table; entry i selects slave i
TIMEOUT, 64, cycles in RD_WAIT before abort (>=2)
ERR_DATA, 32'hDEAD_BEEF, read data returned on error

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
m_en  in  1  master request
m_rdwr  in  1  1=write, 0=read
m_mask  in  4  byte enables
m_addr  in  32  byte address
m_wr_data  in  32  write data
m_rd_data  out  32  read data (registered)
m_rd_valid  out  1  read data valid pulse
m_stall  out  1  router busy; request not accepted
s_en  out  NUM_SLAVES  one-hot slave enable
s_rdwr  out  1  broadcast m_rdwr
s_mask  out  4  broadcast m_mask
s_addr  out  32  {m_addr[31:2],2'b00}
s_wr_data  out  32  broadcast m_wr_data
s_rd_data  in  NUM_SLAVES*32  slave read data, slave i at [32i+:32]
s_rd_valid  in  NUM_SLAVES  slave read-data valid
bus_err  out  1  one-cycle pulse per error
err_addr  out  32  address of most recent error
err_cnt  out  8  saturating error count
err_clr  in  1  synchronous clear of err_cnt/err_addr

Behaviour:
- Reset (rst=0): state IDLE; m_rd_data=0, m_rd_valid=0, bus_err=0, err_addr=0, err_cnt=0, sel=0, timeout counter=0. m_stall is low in IDLE.
- Decode (combinational): hit[i] = (m_addr tag field == SLAVE_TAGS[i]). If several hit, the lowest index wins. No hit means unmapped.
- Acceptance: a request is accepted when m_en && !m_stall.
- s_en[i] = m_en & win[i] & !m_stall. The address is always word-aligned.
- States: IDLE, RD_WAIT. m_stall = (state==RD_WAIT).
- Write, mapped: posted; s_en pulses in the accept cycle. No response, no state change.
- Write, unmapped: dropped; all s_en stay 0; error logged.
- Read, mapped: latch sel and m_addr; clear the counter; IDLE->RD_WAIT.
- In RD_WAIT, s_rd_valid[sel]=1:
  - m_rd_data <= s_rd_data[sel], m_rd_valid <= 1 on the next edge; state -> IDLE.
  - Example: a 1-cycle slave gives en@T0, s_rd_valid@T1, m_rd_valid@T2.
  - A new request may be accepted in the m_rd_valid cycle.
- In RD_WAIT, counter reaches TIMEOUT-1 without valid: m_rd_data<=ERR_DATA, m_rd_valid<=1, error logged with the latched address; state -> IDLE.
- Read, unmapped: no stall; next cycle m_rd_valid=1 with ERR_DATA; error logged.
- s_rd_valid from a non-selected slave, or any s_rd_valid in IDLE: ignored. A late response from a timed-out slave is therefore discarded.
- Error log:
  - bus_err pulses the cycle after detection.
  - err_addr <= offending byte address.
  - err_cnt += 1, saturating at 255.
  - err_clr has priority over a simultaneous error: the result is cnt=0, addr=0, and bus_err still pulses.
- Timeout counter width: $clog2(TIMEOUT). It counts only in RD_WAIT.
- Reset mid-read: returns to IDLE immediately; no m_rd_valid is produced.

Decomposition:
- sys_bus_pkg holds:
  - state enum (IDLE, RD_WAIT)
  - RDWR_READ/RDWR_WRITE constants
  - default ERR_DATA
  - TAG_W default
  - tags for data memory (4'h0) and GEMM (4'h9)
- Sub-module sys_bus_decoder (combinational): tag table + address -> one-hot win, index, mapped flag, with lowest-index priority.

Test Plan:
1. Read tag 4'h0 with a 1-cycle slave returning 32'h1234_5678 -> s_en=01 @T0, m_stall=1 @T1, m_rd_valid with 32'h1234_5678 @T2, no bus_err.
2. Write tag 4'h9, mask 4'b0011 -> s_en=10 for exactly one cycle, s_addr word-aligned (0x9000_0006 -> 0x9000_0004), no stall.
3. Read 0x5000_0000 (unmapped) -> next cycle m_rd_valid with 32'hDEAD_BEEF, bus_err pulse, err_addr=0x5000_0000, err_cnt=1.
4. Slave 1 never answers, TIMEOUT=8 -> m_stall high for 8 cycles, then ERR_DATA with bus_err; a late s_rd_valid[1] is ignored.
5. Back-to-back reads to slave 0 with a 3-cycle slave; stray s_rd_valid[1] asserted during RD_WAIT -> only slave 0 data returned; second request accepted in the m_rd_valid cycle.
6. 260 unmapped writes, then err_clr asserted together with one more error -> err_cnt saturates at 255, then reads 0 after the clear; rst low during RD_WAIT -> IDLE, no m_rd_valid.

Source files
------------

// File: rtl/sys_bus_pkg.sv
// Shared types and constants for the system-bus router and its address decoder.
package sys_bus_pkg;

    typedef enum logic {
        StIdle   = 1'b0,
        StRdWait = 1'b1
    } bus_state_t;

    localparam logic RDWR_READ  = 1'b0;
    localparam logic RDWR_WRITE = 1'b1;

    localparam logic [31:0]  DEF_ERR_DATA = 32'hDEAD_BEEF;
    localparam int unsigned  DEF_TAG_W    = 4;

    localparam logic [3:0] TAG_DMEM = 4'h0;
    localparam logic [3:0] TAG_GEMM = 4'h9;

    // Index width that stays legal for a single-slave build.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sys_bus_decoder.sv
// Combinational tag decoder: matches the top address bits against the tag table and
// returns a one-hot winner, its index and a mapped flag (lowest index wins).
module sys_bus_decoder
    import sys_bus_pkg::*;
#(
    parameter int unsigned                   NUM_SLAVES = 2,
    parameter int unsigned                   TAG_W      = DEF_TAG_W,
    parameter logic [NUM_SLAVES*TAG_W-1:0]   SLAVE_TAGS = {TAG_DMEM, TAG_GEMM},
    localparam int unsigned                  IDX_W      = idx_width(NUM_SLAVES)
) (
    input  logic [31:0]           i_addr,
    output logic [NUM_SLAVES-1:0] o_win,
    output logic [IDX_W-1:0]      o_idx,
    output logic                  o_mapped
);

    logic [TAG_W-1:0]      w_tag;
    logic [NUM_SLAVES-1:0] w_hit;

    assign w_tag = i_addr[31 -: TAG_W];

    // Entry 0 is the leftmost (most significant) field of the tag table.
    always_comb begin
        w_hit = '0;
        for (int i = 0; i < int'(NUM_SLAVES); i++) begin
            w_hit[i] = (w_tag == SLAVE_TAGS[(NUM_SLAVES - 1 - i) * TAG_W +: TAG_W]);
        end
    end

    // Scan from the top so the lowest matching index is the last one written.
    always_comb begin
        o_win    = '0;
        o_idx    = '0;
        o_mapped = |w_hit;
        for (int i = int'(NUM_SLAVES) - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                o_win    = '0;
                o_win[i] = 1'b1;
                o_idx    = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/sys_bus_router.sv
// N-slave data-port router: tag decode, posted writes, stalled variable-latency reads
// with timeout, error responses and a saturating error log.
module sys_bus_router
    import sys_bus_pkg::*;
#(
    parameter int unsigned                 NUM_SLAVES = 2,
    parameter int unsigned                 TAG_W      = DEF_TAG_W,
    parameter logic [NUM_SLAVES*TAG_W-1:0] SLAVE_TAGS = {TAG_DMEM, TAG_GEMM},
    parameter int unsigned                 TIMEOUT    = 64,
    parameter logic [31:0]                 ERR_DATA   = DEF_ERR_DATA
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       m_en,
    input  logic                       m_rdwr,
    input  logic [3:0]                 m_mask,
    input  logic [31:0]                m_addr,
    input  logic [31:0]                m_wr_data,
    output logic [31:0]                m_rd_data,
    output logic                       m_rd_valid,
    output logic                       m_stall,
    output logic [NUM_SLAVES-1:0]      s_en,
    output logic                       s_rdwr,
    output logic [3:0]                 s_mask,
    output logic [31:0]                s_addr,
    output logic [31:0]                s_wr_data,
    input  logic [NUM_SLAVES*32-1:0]   s_rd_data,
    input  logic [NUM_SLAVES-1:0]      s_rd_valid,
    output logic                       bus_err,
    output logic [31:0]                err_addr,
    output logic [7:0]                 err_cnt,
    input  logic                       err_clr
);

    localparam int unsigned     IDX_W    = idx_width(NUM_SLAVES);
    localparam int unsigned     CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    bus_state_t            r_state, w_state_nxt;
    logic [IDX_W-1:0]      r_sel, w_sel_nxt;
    logic [31:0]           r_addr, w_addr_nxt;
    logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
    logic [31:0]           r_rd_data, w_rd_data_nxt;
    logic                  r_rd_valid, w_rd_valid_nxt;
    logic                  r_bus_err;
    logic [31:0]           r_err_addr;
    logic [7:0]            r_err_cnt;

    logic [NUM_SLAVES-1:0] w_win;
    logic [IDX_W-1:0]      w_idx;
    logic                  w_mapped;
    logic                  w_accept;
    logic                  w_sel_valid;
    logic [31:0]           w_sel_data;
    logic                  w_err;
    logic [31:0]           w_err_addr;

    sys_bus_decoder #(
        .NUM_SLAVES (NUM_SLAVES),
        .TAG_W      (TAG_W),
        .SLAVE_TAGS (SLAVE_TAGS)
    ) u_decoder (
        .i_addr   (m_addr),
        .o_win    (w_win),
        .o_idx    (w_idx),
        .o_mapped (w_mapped)
    );

    assign m_stall     = (r_state == StRdWait);
    assign w_accept    = m_en && !m_stall;
    assign s_en        = w_accept ? w_win : '0;
    assign s_rdwr      = m_rdwr;
    assign s_mask      = m_mask;
    assign s_addr      = {m_addr[31:2], 2'b00};
    assign s_wr_data   = m_wr_data;

    assign w_sel_valid = s_rd_valid[r_sel];
    assign w_sel_data  = s_rd_data[32*r_sel +: 32];

    assign m_rd_data   = r_rd_data;
    assign m_rd_valid  = r_rd_valid;
    assign bus_err     = r_bus_err;
    assign err_addr    = r_err_addr;
    assign err_cnt     = r_err_cnt;

    always_comb begin
        w_state_nxt    = r_state;
        w_sel_nxt      = r_sel;
        w_addr_nxt     = r_addr;
        w_cnt_nxt      = r_cnt;
        w_rd_data_nxt  = r_rd_data;
        w_rd_valid_nxt = 1'b0;
        w_err          = 1'b0;
        w_err_addr     = m_addr;

        unique case (r_state)
            StIdle: begin
                if (w_accept) begin
                    if (!w_mapped) begin
                        w_err      = 1'b1;
                        w_err_addr = m_addr;
                        if (m_rdwr == RDWR_READ) begin
                            w_rd_data_nxt  = ERR_DATA;
                            w_rd_valid_nxt = 1'b1;
                        end
                    end else if (m_rdwr == RDWR_READ) begin
                        w_sel_nxt   = w_idx;
                        w_addr_nxt  = m_addr;
                        w_cnt_nxt   = '0;
                        w_state_nxt = StRdWait;
                    end
                end
            end
            StRdWait: begin
                // A valid arriving on the last counted cycle still wins over the abort.
                if (w_sel_valid) begin
                    w_rd_data_nxt  = w_sel_data;
                    w_rd_valid_nxt = 1'b1;
                    w_state_nxt    = StIdle;
                end else if (r_cnt == CNT_LAST) begin
                    w_rd_data_nxt  = ERR_DATA;
                    w_rd_valid_nxt = 1'b1;
                    w_err          = 1'b1;
                    w_err_addr     = r_addr;
                    w_state_nxt    = StIdle;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= StIdle;
            r_sel      <= '0;
            r_addr     <= '0;
            r_cnt      <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_sel      <= w_sel_nxt;
            r_addr     <= w_addr_nxt;
            r_cnt      <= w_cnt_nxt;
            r_rd_data  <= w_rd_data_nxt;
            r_rd_valid <= w_rd_valid_nxt;
        end
    end

    // Clear wins over a coincident error, but the error still pulses bus_err.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bus_err  <= 1'b0;
            r_err_addr <= '0;
            r_err_cnt  <= '0;
        end else begin
            r_bus_err <= w_err;
            if (err_clr) begin
                r_err_addr <= '0;
                r_err_cnt  <= '0;
            end else if (w_err) begin
                r_err_addr <= w_err_addr;
                if (r_err_cnt != 8'hFF) begin
                    r_err_cnt <= r_err_cnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sys_bus_router.sv
// Scoreboard bench for sys_bus_router: directed scenarios plus random traffic against
// a transaction-level model, with a behavioural slave responder.
module tb_sys_bus_router;
    import sys_bus_pkg::*;

    localparam int              NS   = 2;
    localparam int              TO   = 8;
    localparam int              LATE = TO + 4;
    localparam logic [31:0]     ERRD = 32'hDEAD_BEEF;
    localparam logic [NS*4-1:0] TAGS = {4'h0, 4'h9};

    logic              clk = 1'b0;
    logic              rst;
    logic              m_en;
    logic              m_rdwr;
    logic [3:0]        m_mask;
    logic [31:0]       m_addr;
    logic [31:0]       m_wr_data;
    logic [31:0]       m_rd_data;
    logic              m_rd_valid;
    logic              m_stall;
    logic [NS-1:0]     s_en;
    logic              s_rdwr;
    logic [3:0]        s_mask;
    logic [31:0]       s_addr;
    logic [31:0]       s_wr_data;
    logic [NS*32-1:0]  s_rd_data;
    logic [NS-1:0]     s_rd_valid;
    logic              bus_err;
    logic [31:0]       err_addr;
    logic [7:0]        err_cnt;
    logic              err_clr;

    sys_bus_router #(
        .NUM_SLAVES (NS),
        .TAG_W      (4),
        .SLAVE_TAGS (TAGS),
        .TIMEOUT    (TO),
        .ERR_DATA   (ERRD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .m_en       (m_en),
        .m_rdwr     (m_rdwr),
        .m_mask     (m_mask),
        .m_addr     (m_addr),
        .m_wr_data  (m_wr_data),
        .m_rd_data  (m_rd_data),
        .m_rd_valid (m_rd_valid),
        .m_stall    (m_stall),
        .s_en       (s_en),
        .s_rdwr     (s_rdwr),
        .s_mask     (s_mask),
        .s_addr     (s_addr),
        .s_wr_data  (s_wr_data),
        .s_rd_data  (s_rd_data),
        .s_rd_valid (s_rd_valid),
        .bus_err    (bus_err),
        .err_addr   (err_addr),
        .err_cnt    (err_cnt),
        .err_clr    (err_clr)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_rd_q[$];
    logic [39:0] exp_err_q[$];
    int          model_cnt = 0;
    logic [3:0]  tag_tab[NS] = '{4'h0, 4'h9};
    int          rsp_lat[NS];
    logic [31:0] rsp_dat[NS];
    int          cd[NS];
    logic [31:0] dat[NS];
    bit          stray_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int slave_of(input logic [31:0] a);
        for (int i = 0; i < NS; i++) begin
            if (a[31:28] == tag_tab[i]) return i;
        end
        return -1;
    endfunction

    task automatic log_err(input logic [31:0] a, input bit clr);
        if (clr) begin
            model_cnt = 0;
            exp_err_q.push_back(40'h0);
        end else begin
            if (model_cnt < 255) model_cnt++;
            exp_err_q.push_back({a, 8'(model_cnt)});
        end
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (m_stall === 1'b1 && n < 200) begin
            n++;
            @(posedge clk);
            #1;
        end
    endtask

    // One request: drive, queue the expected response, check the slave side, then wait.
    task automatic do_txn(input bit wr, input logic [31:0] a, input logic [3:0] mask,
                          input logic [31:0] wd, input int lat, input logic [31:0] rdat,
                          input bit clr);
        int s;
        int n;
        int exp_n;
        s = slave_of(a);
        if (s >= 0 && !wr) begin
            rsp_lat[s] = lat;
            rsp_dat[s] = rdat;
        end
        m_en      = 1'b1;
        m_rdwr    = wr ? RDWR_WRITE : RDWR_READ;
        m_addr    = a;
        m_mask    = mask;
        m_wr_data = wd;
        err_clr   = clr;
        if (s < 0) begin
            if (!wr) exp_rd_q.push_back(ERRD);
            log_err(a, clr);
        end else if (!wr) begin
            if (lat <= TO) begin
                exp_rd_q.push_back(rdat);
            end else begin
                exp_rd_q.push_back(ERRD);
                log_err(a, 1'b0);
            end
        end
        #1;
        chk("s_en", 32'(s_en), (s >= 0) ? (32'd1 << s) : 32'd0);
        chk("s_addr", s_addr, {a[31:2], 2'b00});
        if (wr) begin
            chk("s_mask", 32'(s_mask), 32'(mask));
            chk("s_wr_data", s_wr_data, wd);
        end
        @(posedge clk);
        #1;
        m_en    = 1'b0;
        err_clr = 1'b0;
        #1;
        chk("s_en_pulse", 32'(s_en), 32'd0);
        exp_n = (s >= 0 && !wr) ? ((lat <= TO) ? lat : TO) : 0;
        wait_idle(n);
        chk("stall_cycles", n, exp_n);
    endtask

    // Slave responder: latency countdown per slave, optional stray valids on idle slaves.
    initial begin
        s_rd_valid = '0;
        s_rd_data  = '0;
        for (int i = 0; i < NS; i++) cd[i] = 0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < NS; i++) begin
                if (s_en[i] === 1'b1 && s_rdwr == RDWR_READ) begin
                    cd[i]  = rsp_lat[i];
                    dat[i] = rsp_dat[i];
                end
            end
            @(posedge clk);
            #1;
            for (int i = 0; i < NS; i++) begin
                s_rd_valid[i]          = 1'b0;
                s_rd_data[i*32 +: 32]  = $urandom;
                if (cd[i] > 0) begin
                    cd[i]--;
                    if (cd[i] == 0) begin
                        s_rd_valid[i]         = 1'b1;
                        s_rd_data[i*32 +: 32] = dat[i];
                    end
                end else if (stray_en && $urandom_range(0, 3) == 0) begin
                    s_rd_valid[i] = 1'b1;
                end
            end
        end
    end

    // Monitor: every response or error pulse must match the head of its queue.
    initial begin
        logic [39:0] e;
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                if (m_rd_valid === 1'b1) begin
                    if (exp_rd_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_rd_valid actual=%h required=none at %0t",
                                 m_rd_data, $time);
                    end else begin
                        chk("m_rd_data", m_rd_data, exp_rd_q.pop_front());
                    end
                end
                if (bus_err === 1'b1) begin
                    if (exp_err_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_bus_err actual=%h required=none at %0t",
                                 err_addr, $time);
                    end else begin
                        e = exp_err_q.pop_front();
                        chk("err_addr", err_addr, e[39:8]);
                        chk("err_cnt", 32'(err_cnt), 32'(e[7:0]));
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          n;
        logic [3:0]  tg;
        logic [31:0] a;
        bit          wr;
        int          lat;

        rst = 1'b0; m_en = 1'b0; m_rdwr = 1'b0; m_mask = '0;
        m_addr = '0; m_wr_data = '0; err_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_rd_data", m_rd_data, 32'd0);
        chk("rst_m_rd_valid", 32'(m_rd_valid), 32'd0);
        chk("rst_m_stall", 32'(m_stall), 32'd0);
        chk("rst_bus_err", 32'(bus_err), 32'd0);
        chk("rst_err_addr", err_addr, 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        do_txn(1'b0, 32'h0000_0010, 4'hF, 32'd0, 1, 32'h1234_5678, 1'b0);
        do_txn(1'b1, 32'h9000_0006, 4'b0011, 32'hCAFE_F00D, 1, 32'd0, 1'b0);
        do_txn(1'b0, 32'h5000_0000, 4'hF, 32'd0, 1, 32'd0, 1'b0);

        stray_en = 1'b1;
        do_txn(1'b0, 32'h9000_0100, 4'hF, 32'd0, LATE, 32'h1111_2222, 1'b0);
        do_txn(1'b0, 32'h0000_0200, 4'hF, 32'd0, 3, 32'hA0A0_0001, 1'b0);
        chk("rd_valid_in_accept_cycle", 32'(m_rd_valid), 32'd1);
        do_txn(1'b0, 32'h0000_0204, 4'hF, 32'd0, 3, 32'hA0A0_0002, 1'b0);

        for (int k = 0; k < 150; k++) begin
            n = $urandom_range(0, 9);
            if (n < 4) begin
                tg = 4'h0;
            end else if (n < 8) begin
                tg = 4'h9;
            end else begin
                tg = 4'($urandom_range(1, 14));
                if (tg == 4'h9) tg = 4'hF;
            end
            a        = {tg, 28'($urandom)};
            wr       = ($urandom_range(0, 2) == 0);
            lat      = ($urandom_range(0, 4) == 0) ? LATE : $urandom_range(1, 6);
            stray_en = ($urandom_range(0, 1) == 1);
            do_txn(wr, a, 4'($urandom), $urandom, lat, $urandom, 1'b0);
        end

        stray_en = 1'b0;
        for (int k = 0; k < 260; k++) begin
            do_txn(1'b1, {4'h5, 28'(k * 4)}, 4'hF, $urandom, 1, 32'd0, 1'b0);
        end
        do_txn(1'b1, 32'h7000_0000, 4'hF, 32'd0, 1, 32'd0, 1'b1);
        @(posedge clk);
        #1;
        chk("err_cnt_cleared", 32'(err_cnt), 32'd0);
        chk("err_addr_cleared", err_addr, 32'd0);

        repeat (LATE + 4) @(posedge clk);
        #1;
        chk("rd_queue_drained", exp_rd_q.size(), 32'd0);
        chk("err_queue_drained", exp_err_q.size(), 32'd0);

        rsp_lat[1] = LATE;
        rsp_dat[1] = 32'h5555_AAAA;
        m_en   = 1'b1;
        m_rdwr = RDWR_READ;
        m_addr = 32'h9000_0040;
        @(posedge clk);
        #1;
        m_en = 1'b0;
        @(posedge clk);
        #1;
        chk("stall_before_reset", 32'(m_stall), 32'd1);
        rst = 1'b0;
        #1;
        chk("stall_in_reset", 32'(m_stall), 32'd0);
        chk("rd_valid_in_reset", 32'(m_rd_valid), 32'd0);
        model_cnt = 0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (LATE + 4) @(posedge clk);
        #1;
        chk("stall_after_reset", 32'(m_stall), 32'd0);
        chk("rd_queue_after_reset", exp_rd_q.size(), 32'd0);
        chk("err_cnt_after_reset", 32'(err_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
